// File: rtl/rs_encoder_framer.sv
// RS(255,239) systematic encoder and framer feeding RSdecoder.
// Emits a continuous stream of 255-symbol codewords after the first in_valid;
// sync is high only between reset and the start of streaming.
module rs_encoder_framer #(
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic       clk_in,
    input  logic       sys_rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       sync,
    output logic [7:0] data_out,
    output logic       sof,
    output logic       err_underrun
);

    localparam int unsigned SYM_W  = 8;
    localparam int unsigned NPAR   = 16;
    localparam int unsigned K_SYMS = 239;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(K_SYMS - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(NPAR - 1);

    // GF(2^8) multiply, field polynomial 0x11D; folds to XORs with a constant operand
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Generator coefficients g0..g15 of prod (x - alpha^i), i = 0..15
    function automatic logic [NPAR*SYM_W-1:0] gen_poly();
        logic [NPAR:0][SYM_W-1:0] c;
        logic [SYM_W-1:0]         root;
        logic [NPAR*SYM_W-1:0]    res;
        c    = '0;
        c[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j > 0; j--) begin
                c[j] = c[j-1] ^ gf_mul(c[j], root);
            end
            c[0] = gf_mul(c[0], root);
            root = gf_mul(root, 8'h02);
        end
        for (int j = 0; j < NPAR; j++) begin
            res[j*SYM_W +: SYM_W] = c[j];
        end
        return res;
    endfunction

    localparam logic [NPAR*SYM_W-1:0] GEN = gen_poly();

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [NPAR-1:0][SYM_W-1:0]  lfsr;

    logic [SYM_W-1:0]            sym;
    logic [SYM_W-1:0]            fb;
    logic [NPAR-1:0][SYM_W-1:0]  lfsr_msg;
    logic [NPAR-1:0][SYM_W-1:0]  lfsr_shift;

    // Symbol selection and the two LFSR next-state candidates
    always_comb begin
        sym         = in_valid ? in_data : FILL_BYTE;
        fb          = sym ^ lfsr[NPAR-1];
        lfsr_msg    = '0;
        lfsr_msg[0] = gf_mul(GEN[SYM_W-1:0], fb);
        for (int i = 1; i < NPAR; i++) begin
            lfsr_msg[i] = lfsr[i-1] ^ gf_mul(GEN[i*SYM_W +: SYM_W], fb);
        end
        lfsr_shift = {lfsr[NPAR-2:0], SYM_W'(0)};
    end

    // Framing FSM, LFSR and registered outputs
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lfsr         <= '0;
            sync         <= 1'b1;
            data_out     <= '0;
            in_ready     <= 1'b0;
            sof          <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_MSG;
                        sync     <= 1'b0;
                        in_ready <= 1'b1;
                        cnt      <= '0;
                    end
                end
                ST_MSG: begin
                    data_out <= sym;
                    sof      <= (cnt == '0);
                    lfsr     <= lfsr_msg;
                    if (!in_valid) err_underrun <= 1'b1;
                    if (cnt == MSG_LAST) begin
                        state    <= ST_PAR;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PAR: begin
                    data_out <= lfsr[NPAR-1];
                    sof      <= 1'b0;
                    lfsr     <= lfsr_shift;
                    if (cnt == PAR_LAST) begin
                        state    <= ST_MSG;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_framer.sv
// Bench for rs_encoder_framer: polynomial-division reference, syndrome checks,
// known parity vectors, frame timing, underrun fill and mid-frame reset.
module tb_rs_encoder_framer;

    localparam logic [7:0] FILL = 8'h00;

    logic       clk_in = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       sync;
    logic [7:0] data_out;
    logic       sof;
    logic       err_underrun;

    rs_encoder_framer #(.FILL_BYTE(FILL)) dut (
        .clk_in       (clk_in),
        .sys_rst_n    (sys_rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .sync         (sync),
        .data_out     (data_out),
        .sof          (sof),
        .err_underrun (err_underrun)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    logic err_m = 1'b0;

    logic [7:0] msg    [0:3][0:238];
    bit         vmask  [0:3][0:238];
    logic [7:0] expcw  [0:3][0:254];
    logic [7:0] cap    [0:3][0:254];
    logic [7:0] gen    [0:16];

    logic [7:0] par_ones [0:15] = '{8'd185, 8'd20, 8'd223, 8'd201, 8'd145, 8'd106, 8'd254, 8'd175,
                                    8'd6, 8'd15, 8'd150, 8'd25, 8'd134, 8'd84, 8'd232, 8'd172};
    logic [7:0] par_x    [0:15] = '{8'd44, 8'd179, 8'd224, 8'd77, 8'd193, 8'd133, 8'd17, 8'd187,
                                    8'd207, 8'd63, 8'd171, 8'd4, 8'd53, 8'd242, 8'd149, 8'd208};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int pa, pb, r;
        pa = a; pb = b; r = 0;
        while (pb != 0) begin
            if (pb & 1) r = r ^ pa;
            pa = pa << 1;
            if (pa & 256) pa = pa ^ 'h11D;
            pb = pb >> 1;
        end
        return 8'(r);
    endfunction

    // gen[d] = coefficient of x^d of prod (x + alpha^i)
    function automatic void build_gen();
        logic [7:0] root;
        logic [7:0] nxt [0:16];
        for (int d = 0; d <= 16; d++) gen[d] = 8'h00;
        gen[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d <= 16; d++)
                nxt[d] = gmul(gen[d], root) ^ ((d > 0) ? gen[d-1] : 8'h00);
            for (int d = 0; d <= 16; d++) gen[d] = nxt[d];
            root = gmul(root, 8'h02);
        end
    endfunction

    // Codeword = message || (message * x^16 mod g), by long division
    function automatic void build_expected(input int f);
        logic [7:0] rem [0:254];
        logic [7:0] q;
        for (int i = 0; i < 255; i++)
            rem[i] = (i < 239) ? (vmask[f][i] ? msg[f][i] : FILL) : 8'h00;
        for (int i = 0; i < 239; i++) expcw[f][i] = rem[i];
        for (int j = 0; j < 239; j++) begin
            q = rem[j];
            for (int k = 0; k <= 16; k++) rem[j+k] = rem[j+k] ^ gmul(q, gen[16-k]);
        end
        for (int k = 0; k < 16; k++) expcw[f][239+k] = rem[239+k];
    endfunction

    function automatic bit captured_is_codeword(input int f);
        logic [7:0] root, acc;
        bit ok;
        ok = 1'b1;
        root = 8'h01;
        for (int r = 0; r < 16; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 255; j++) acc = gmul(acc, root) ^ cap[f][j];
            if (acc !== 8'h00) ok = 1'b0;
            root = gmul(root, 8'h02);
        end
        return ok;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
        err_m = 1'b0;
        step();
    endtask

    // Start from IDLE and stream nframes frames back to back, checking every cycle
    task automatic run_stream(input int nframes);
        bit exp_ready;
        in_valid = 1'b0;
        step();
        checks++;
        if (sync !== 1'b1) begin failures++; $display("FAIL idle_sync got=%0b exp=1", sync); end
        in_valid = 1'b1;
        in_data = msg[0][0];
        step();
        checks++;
        if (sync !== 1'b0 || in_ready !== 1'b1 || sof !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL start sync=%0b ready=%0b sof=%0b data=%0d exp sync=0 ready=1 sof=0 data=0",
                     sync, in_ready, sof, data_out);
        end
        for (int f = 0; f < nframes; f++) begin
            build_expected(f);
            for (int i = 0; i < 255; i++) begin
                if (i < 239) begin
                    in_valid = vmask[f][i];
                    in_data = vmask[f][i] ? msg[f][i] : 8'($urandom);
                end else begin
                    in_valid = 1'($urandom);
                    in_data = 8'($urandom);
                end
                step();
                if (i < 239 && !vmask[f][i]) err_m = 1'b1;
                cap[f][i] = data_out;
                exp_ready = (i < 238) || (i == 254);
                checks++;
                if (data_out !== expcw[f][i]) begin
                    failures++;
                    $display("FAIL data f=%0d i=%0d got=%0d exp=%0d", f, i, data_out, expcw[f][i]);
                end
                checks++;
                if (sof !== (i == 0)) begin
                    failures++;
                    $display("FAIL sof f=%0d i=%0d got=%0b exp=%0b", f, i, sof, (i == 0));
                end
                checks++;
                if (in_ready !== exp_ready) begin
                    failures++;
                    $display("FAIL in_ready f=%0d i=%0d got=%0b exp=%0b", f, i, in_ready, exp_ready);
                end
                checks++;
                if (sync !== 1'b0) begin
                    failures++;
                    $display("FAIL sync f=%0d i=%0d got=%0b exp=0", f, i, sync);
                end
                checks++;
                if (err_underrun !== err_m) begin
                    failures++;
                    $display("FAIL err_underrun f=%0d i=%0d got=%0b exp=%0b", f, i, err_underrun, err_m);
                end
            end
            checks++;
            if (!captured_is_codeword(f)) begin
                failures++;
                $display("FAIL syndrome f=%0d got=nonzero exp=zero", f);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int f);
        for (int i = 0; i < 239; i++) begin
            msg[f][i] = 8'($urandom);
            vmask[f][i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        step();
        checks++;
        if (sync !== 1'b1 || data_out !== 8'h00 || in_ready !== 1'b0 || sof !== 1'b0 || err_underrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_values sync=%0b data=%0d ready=%0b sof=%0b err=%0b exp 1/0/0/0/0",
                     sync, data_out, in_ready, sof, err_underrun);
        end
        in_valid = 1'b0;
        sys_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (sync !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold c=%0d sync=%0b ready=%0b exp sync=1 ready=0", c, sync, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 239; i++) begin
            msg[0][i] = 8'h01;
            msg[1][i] = (i == 1) ? 8'h01 : 8'h00;
            msg[2][i] = 8'h00;
            vmask[0][i] = 1'b1; vmask[1][i] = 1'b1; vmask[2][i] = 1'b1;
        end
        run_stream(3);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (cap[0][239+k] !== par_ones[k]) begin
                failures++;
                $display("FAIL known_ones k=%0d got=%0d exp=%0d", k, cap[0][239+k], par_ones[k]);
            end
            checks++;
            if (cap[1][239+k] !== par_x[k]) begin
                failures++;
                $display("FAIL known_x k=%0d got=%0d exp=%0d", k, cap[1][239+k], par_x[k]);
            end
            checks++;
            if (cap[2][239+k] !== 8'h00) begin
                failures++;
                $display("FAIL zero_parity k=%0d got=%0d exp=0", k, cap[2][239+k]);
            end
        end
    endtask

    task automatic test_random_frames();
        do_reset();
        fill_random(0);
        fill_random(1);
        run_stream(2);
    endtask

    task automatic test_underrun();
        do_reset();
        fill_random(0);
        fill_random(1);
        for (int i = 100; i < 105; i++) vmask[0][i] = 1'b0;
        run_stream(2);
        checks++;
        if (err_underrun !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%0b exp=1", err_underrun);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        fill_random(0);
        in_valid = 1'b1;
        in_data = msg[0][0];
        step();
        for (int i = 0; i < 100; i++) begin
            in_data = msg[0][i];
            step();
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (sync !== 1'b1 || data_out !== 8'h00 || in_ready !== 1'b0 || sof !== 1'b0 || err_underrun !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset sync=%0b data=%0d ready=%0b sof=%0b err=%0b exp 1/0/0/0/0",
                     sync, data_out, in_ready, sof, err_underrun);
        end
        in_valid = 1'b0;
        step();
        sys_rst_n = 1'b1;
        err_m = 1'b0;
        fill_random(0);
        run_stream(1);
    endtask

    initial begin
        build_gen();
        test_reset();
        test_back_to_back();
        test_random_frames();
        test_underrun();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_encoder_framer.md
# rs_encoder_framer

Upstream stage of `RSdecoder`. Accepts a byte stream of message symbols with a valid/ready handshake and computes RS(255,239) parity over GF(2^8) with a systematic LFSR encoder. Emits an unbroken 255-symbol codeword stream on `data_out`, with the `sync` framing convention `RSdecoder` consumes: `sync` high while idle, low from one cycle before the first codeword symbol onward, and frames back-to-back with no gaps.

## Interface
Parameters:
- `FILL_BYTE`, 8'h00: symbol substituted when upstream underruns during a message phase.

Ports:
- `clk_in`  in  1  single system clock; all state updates on its rising edge.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream has a message byte on `in_data`.
- `in_data`  in  8  message symbol.
- `in_ready`  out  1  encoder consumes a message symbol this cycle.
- `sync`  out  1  frame sync to `RSdecoder`: 1 idle, 0 once streaming.
- `data_out`  out  8  codeword symbol stream to `RSdecoder.data_in`.
- `sof`  out  1  one-cycle pulse coincident with symbol 0 of each codeword on `data_out`.
- `err_underrun`  out  1  sticky flag: a fill symbol was inserted.

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02.
- Generator: g(x) = Π_{i=0..15} (x − α^i). The 16 coefficients g0..g15 are constants. The monic x^16 term is implicit.
- Code: n=255, k=239. Message symbols go out first, highest-degree first, unmodified. Parity follows, p15 (highest degree) first.
- LFSR: 16 × 8-bit registers r0..r15.
  - On each accepted or filled message symbol s: fb = s ^ r15; r_i ← r_{i−1} ^ g_i·fb; r0 ← g0·fb.
  - In the parity phase: shift r_i ← r_{i−1}, r0 ← 0, and output r15.
  - After 16 parity shifts the LFSR is all-zero, so there is no explicit clear between frames.
- GF multiply by constant: XOR network. No lookup RAM.
- State machine:
  - IDLE: `sync`=1, `in_ready`=0. `in_valid`=1 → MSG; `sync` drops to 0 on that edge.
  - MSG (count 0..238): `in_ready`=1. Symbol = `in_data` if `in_valid`, else `FILL_BYTE`; the fill case sets `err_underrun`. Count 238 → PAR.
  - PAR (count 0..15): `in_ready`=0; upstream data is ignored. Count 15 → MSG, never back to IDLE.
- Once streaming, the codeword stream is continuous forever. Only reset returns the block to IDLE.
- `sync` never returns to 1 except through reset.
- `err_underrun` clears only on reset.

## Timing
- Reset values (asynchronous): state IDLE, counters 0, LFSR 0, `sync`=1, `data_out`=0, `in_ready`=0, `sof`=0, `err_underrun`=0.
- `in_ready` is decoded from state only, with no combinational path from `in_valid`.
- Latency: a symbol consumed at edge E appears on `data_out` from E until E+1, i.e. 1 cycle, registered.
- Frame start: in cycle T, IDLE sees `in_valid`=1; from edge T, `sync`=0 and state is MSG. Message symbol 0 is consumed at edge T+1 and is on `data_out` in cycle T+2 with `sof`=1.
  - Net: `sync` falls exactly one cycle before symbol 0 appears.
- Per frame: 239 message symbols, then 16 parity symbols, on consecutive cycles. The next frame's symbol 0 immediately follows p0.
- `in_ready` is high for 239 cycles, then low for 16 cycles, with period 255.
- Underrun: `in_ready`=1 and `in_valid`=0 → `FILL_BYTE` is encoded and output. `err_underrun` rises at that edge. Parity remains valid for the filled frame.
- Reset asserted mid-frame: all outputs go to reset values immediately. The partial codeword is abandoned, and the next `in_valid` starts a fresh frame.

## Test plan
- 239 × 0x01 → `data_out` = 239 × 0x01, then 185,20,223,201,145,106,254,175,6,15,150,25,134,84,232,172; `sof` on the first 0x01 only.
- Message 0x00,0x01, then 237 × 0x00 → parity 44,179,224,77,193,133,17,187,207,63,171,4,53,242,149,208.
- Timing checks, from reset release with `in_valid` held high:
  - `sync`=1 until the first `in_valid`, then 0 exactly one cycle before the first symbol.
  - `in_ready` pattern 239 high / 16 low, repeating.
  - Three back-to-back frames with no gap cycles; all-zero message → 16 zero parity symbols.
- Drop `in_valid` for 5 cycles mid-message → five 0x00 symbols inserted, `err_underrun`=1 and sticky, `sync` stays 0, and the frame is still a valid codeword (golden model).
- Assert `sys_rst_n`=0 at message symbol 100 → outputs go to reset values within the same cycle. After release, the next frame matches the golden model with a zero-initialised LFSR.
- Loopback into `RSdecoder`, injecting up to 8 symbol errors per frame between the stages → `RSdecoder.data_out` reproduces the original message.
